// File: rtl/out_checker_pkg.sv
// out_checker_pkg: shared FSM state, default sizes and checkpoint entry type
package out_checker_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int NUM_CHK_DEF = 4;
    localparam int CW_DEF = 16;
    // cycle field sized for the widest supported counter; users keep the low CW bits
    localparam int CYC_W = 32;
    typedef struct packed {
        logic [CYC_W-1:0] cycle;
        logic [7:0]       a;
        logic [7:0]       b;
        logic [7:0]       c;
        logic             d;
    } chk_entry_t;
endpackage

// File: rtl/out_checker_chk_table.sv
// chk_table: checkpoint register file with a live copy frozen at each run start
module chk_table
    import out_checker_pkg::*;
#(
    parameter int NUM_CHK = NUM_CHK_DEF,
    parameter int IW = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [IW-1:0]   widx,
    input  chk_entry_t      wdata,
    input  logic            load,
    input  logic [IW-1:0]   ridx,
    output chk_entry_t      rdata
);
    chk_entry_t tab  [NUM_CHK];
    chk_entry_t live [NUM_CHK];
    // live is copied from tab on the start edge, so a same-edge write only reaches later runs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tab  <= '{default: '0};
            live <= '{default: '0};
        end else begin
            if (we && int'(widx) < NUM_CHK) tab[widx] <= wdata;
            if (load) live <= tab;
        end
    end
    assign rdata = (int'(ridx) < NUM_CHK) ? live[ridx] : '0;
endmodule

// File: rtl/out_checker.sv
// out_checker: compares observed outputs a/b/c/d against a cycle-stamped checkpoint table
module out_checker
    import out_checker_pkg::*;
#(
    parameter int NUM_CHK = NUM_CHK_DEF,
    parameter int CW = CW_DEF,
    localparam int IW = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1,
    localparam int PW = IW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    a,
    input  logic [7:0]    b,
    input  logic [7:0]    c,
    input  logic          d,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [CW-1:0] cfg_cycle,
    input  logic [7:0]    cfg_a,
    input  logic [7:0]    cfg_b,
    input  logic [7:0]    cfg_c,
    input  logic          cfg_d,
    input  logic [PW-1:0] cfg_num,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [7:0]    err_cnt,
    output logic [3:0]    err_fields,
    output logic          missed
);
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n, cyc;
    logic [PW-1:0] ptr, ptr_n, ptr_inc, num, run_num;
    logic [7:0] err_n;
    logic [3:0] fields_n, mism;
    logic [8:0] sum;
    logic missed_n, go, hit, late, retire, timeout;
    chk_entry_t ent;

    assign go = start && state != RUN;

    chk_table #(.NUM_CHK(NUM_CHK), .IW(IW)) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we && state != RUN),
        .widx  (cfg_idx),
        .wdata ({CYC_W'(cfg_cycle), cfg_a, cfg_b, cfg_c, cfg_d}),
        .load  (go),
        .ridx  (ptr[IW-1:0]),
        .rdata (ent)
    );

    assign cyc     = ent.cycle[CW-1:0];
    assign mism    = {d != ent.d, c != ent.c, b != ent.b, a != ent.a};
    assign hit     = cnt == cyc;
    assign late    = cnt > cyc;
    assign retire  = hit || late;
    assign ptr_inc = ptr + PW'(retire);
    // counter exhausted with entries still pending counts as one more miss
    assign timeout = &cnt && ptr_inc < run_num;
    assign sum     = {1'b0, err_cnt} + 9'(hit ? $countones(mism) : int'(late)) + 9'(timeout);
    assign busy    = state == RUN;
    assign done    = state == DONE;
    assign pass    = done && err_cnt == 8'd0;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        ptr_n    = ptr;
        err_n    = err_cnt;
        fields_n = err_fields;
        missed_n = missed;
        if (go) begin
            state_n  = |num ? RUN : DONE;
            cnt_n    = '0;
            ptr_n    = '0;
            err_n    = '0;
            fields_n = '0;
            missed_n = 1'b0;
        end else if (state == RUN) begin
            cnt_n    = cnt + 1'b1;
            ptr_n    = ptr_inc;
            err_n    = sum[8] ? 8'hff : sum[7:0];
            fields_n = err_fields | (hit ? mism : 4'b0);
            missed_n = missed | late | timeout;
            if ((retire && ptr_inc == run_num) || &cnt) state_n = DONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ptr        <= '0;
            err_cnt    <= '0;
            err_fields <= '0;
            missed     <= 1'b0;
            num        <= '0;
            run_num    <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ptr        <= ptr_n;
            err_cnt    <= err_n;
            err_fields <= fields_n;
            missed     <= missed_n;
            if (cfg_we && state != RUN) num <= cfg_num;
            if (go) run_num <= num;
        end
    end
endmodule
